// File: rtl/uart_pkg.sv
// Shared types, parity modes and timing helpers for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } uart_tx_state_t;

  localparam int unsigned PAR_NONE = 32'd0;
  localparam int unsigned PAR_ODD  = 32'd1;
  localparam int unsigned PAR_EVEN = 32'd2;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return (clk_hz + baud / 32'd2) / baud;
  endfunction

  // Parity bit for a byte under the selected mode (odd for anything not even).
  function automatic logic par_bit(input logic [7:0] d, input int unsigned mode);
    logic p;
    if (mode == PAR_EVEN) begin
      p = ^d;
    end else begin
      p = ~^d;
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Clear/enable bit-period counter; bit_end_o marks the clock at the terminal count.
module uart_baud_cnt #(
  parameter int unsigned CW = 32'd4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [CW-1:0] term_i,
  output logic [CW-1:0] cnt_o,
  output logic          bit_end_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_end_o = en_i && (cnt_q == term_i);
  assign cnt_o     = cnt_q;

  // Next count: restart on clear or terminal count, otherwise advance while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || bit_end_o) begin
      cnt_d = {CW{1'b0}};
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_byte.sv
// Byte-wide UART transmitter: LSB first, optional parity, one or two stop bits,
// with a send/busy handshake toward the upstream serializer.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 32'd100_000_000,
  parameter int unsigned BAUD         = 32'd115_200,
  parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD),
  parameter int unsigned PARITY       = PAR_NONE,
  parameter int unsigned STOP_BITS    = 32'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       send,
  output logic       busy,
  output logic       tx,
  output logic       tx_done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT * STOP_BITS);
  localparam logic [CW-1:0] TERM_BIT  = CW'(CLKS_PER_BIT - 32'd1);
  localparam logic [CW-1:0] TERM_STOP = CW'(CLKS_PER_BIT * STOP_BITS - 32'd1);
  localparam logic [CW-1:0] DONE_AT   = CW'(CLKS_PER_BIT * STOP_BITS - 32'd2);

  generate
    if (CLKS_PER_BIT < 32'd4) begin : g_bad_cpb
      $error("uart_tx_byte: CLKS_PER_BIT must be at least 4");
    end
    if ((STOP_BITS != 32'd1) && (STOP_BITS != 32'd2)) begin : g_bad_stop
      $error("uart_tx_byte: STOP_BITS must be 1 or 2");
    end
  endgenerate

  uart_tx_state_t state_q;
  logic [7:0]     shreg_q;
  logic [2:0]     bit_cnt_q;
  logic           par_q;
  logic           tx_q;
  logic           tx_done_q;

  logic [CW-1:0]  term_s;
  logic [CW-1:0]  cnt_s;
  logic           bit_end_s;
  logic           clr_s;
  logic           en_s;

  // The stop phase is timed as one long period so both stop bits share one count.
  always_comb begin
    term_s = TERM_BIT;
    if (state_q == STOP) begin
      term_s = TERM_STOP;
    end else begin
      term_s = TERM_BIT;
    end
  end

  assign clr_s = (state_q == IDLE);
  assign en_s  = (state_q != IDLE);

  uart_baud_cnt #(
    .CW (CW)
  ) u_baud_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (clr_s),
    .en_i      (en_s),
    .term_i    (term_s),
    .cnt_o     (cnt_s),
    .bit_end_o (bit_end_s)
  );

  // Frame sequencer; tx is loaded with the next bit value on each state change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (send) begin
            shreg_q <= data_in;
            par_q   <= par_bit(data_in, PARITY);
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end_s) begin
            bit_cnt_q <= 3'd0;
            tx_q      <= shreg_q[0];
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (bit_end_s) begin
            shreg_q <= {1'b0, shreg_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_q <= 3'd0;
              if (PARITY != PAR_NONE) begin
                tx_q    <= par_q;
                state_q <= PAR;
              end else begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              tx_q      <= shreg_q[1];
            end
          end
        end
        PAR: begin
          if (bit_end_s) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end
        end
        STOP: begin
          // Registered, so raise it one clock early to land on the final stop clock.
          if (cnt_s == DONE_AT) begin
            tx_done_q <= 1'b1;
          end
          if (bit_end_s) begin
            tx_q    <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = (state_q != IDLE) | (send & (state_q == IDLE));
  assign tx      = tx_q;
  assign tx_done = tx_done_q;

endmodule
